// File: rtl/ram_dp_param.sv
// Parametrised simple dual-port synchronous RAM with byte-lane writes,
// a selectable read/write collision policy and a hardware clear sequencer.
module ram_dp_param #(
  parameter int unsigned       DWIDTH         = 8,
  parameter int unsigned       AWIDTH         = 8,
  parameter int unsigned       DEPTH          = 256,
  parameter int unsigned       RD_LATENCY     = 1,
  parameter int unsigned       COLLISION_MODE = 0,
  parameter int unsigned       CLEAR_ON_RESET = 1,
  parameter logic [DWIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic                          RWCLK,
  input  logic                          RESET,
  input  logic                          WEN,
  input  logic [((DWIDTH+7)/8)-1:0]     WBE,
  input  logic [AWIDTH-1:0]             WADDR,
  input  logic [DWIDTH-1:0]             WD,
  input  logic                          REN,
  input  logic [AWIDTH-1:0]             RADDR,
  output logic [DWIDTH-1:0]             RD,
  output logic                          RVALID,
  output logic                          BUSY
);

  localparam int unsigned NBE  = (DWIDTH + 7) / 8;
  localparam int unsigned IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_RUN} state_e;

  logic [DWIDTH-1:0] mem_q [DEPTH];

  state_e            state_q, state_d;
  logic [IW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic [DWIDTH-1:0] rd_q, rd_d;
  logic              rvalid_q, rvalid_d;

  logic [DWIDTH-1:0] lane_mask;
  logic              user_en;
  logic              wr_user;
  logic              clr_we;
  logic              mem_we;
  logic [IW-1:0]     mem_wa;
  logic [DWIDTH-1:0] mem_wd;
  logic [DWIDTH-1:0] mem_wm;
  logic              rd_fire;
  logic              rd_in_range;
  logic [DWIDTH-1:0] old_word;
  logic [DWIDTH-1:0] rd_word;

  // Expand per-lane write enables to a per-bit mask (last lane may be partial)
  for (genvar g = 0; g < int'(DWIDTH); g++) begin : g_mask
    assign lane_mask[g] = WBE[g/8];
  end

  // Clear sequencer next state: one word per clock, then hand over to RUN
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + IW'(1);
        if (cnt_q == LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
    busy_d = (state_d == ST_CLEAR);
  end

  // Write port arbitration: clear sequencer owns the port while busy
  always_comb begin
    user_en = !RESET && !busy_q;
    clr_we  = !RESET && (state_q == ST_CLEAR);
    wr_user = user_en && WEN && (32'(WADDR) < DEPTH);
    mem_we  = 1'b0;
    mem_wa  = '0;
    mem_wd  = '0;
    mem_wm  = '0;
    if (clr_we) begin
      mem_we = 1'b1;
      mem_wa = cnt_q;
      mem_wd = CLEAR_VALUE;
      mem_wm = '1;
    end else if (wr_user && (|WBE)) begin
      mem_we = 1'b1;
      mem_wa = IW'(WADDR);
      mem_wd = WD;
      mem_wm = lane_mask;
    end
  end

  // Read port: old data from the array, optionally bypassed on collision
  always_comb begin
    rd_fire     = user_en && REN;
    rd_in_range = (32'(RADDR) < DEPTH);
    old_word    = rd_in_range ? mem_q[IW'(RADDR)] : '0;
    rd_word     = old_word;
    if ((COLLISION_MODE == 1) && wr_user && rd_in_range && (WADDR == RADDR)) begin
      rd_word = (old_word & ~lane_mask) | (WD & lane_mask);
    end
  end

  // Storage array; never reset, contents only change through the write port
  always_ff @(posedge RWCLK) begin
    if (mem_we) begin
      mem_q[mem_wa] <= (mem_q[mem_wa] & ~mem_wm) | (mem_wd & mem_wm);
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic [DWIDTH-1:0] p_data_q, p_data_d;
    logic              p_valid_q, p_valid_d;

    // Extra stage: data captured at the REN edge is immune to later writes
    always_comb begin
      p_valid_d = rd_fire;
      p_data_d  = rd_fire ? rd_word : p_data_q;
      rvalid_d  = p_valid_q;
      rd_d      = p_valid_q ? p_data_q : rd_q;
    end

    // Pipeline stage registers
    always_ff @(posedge RWCLK) begin
      if (RESET) begin
        p_data_q  <= '0;
        p_valid_q <= 1'b0;
      end else begin
        p_data_q  <= p_data_d;
        p_valid_q <= p_valid_d;
      end
    end
  end else begin : g_lat1
    // Single stage: RD updates on the REN edge, holds otherwise
    always_comb begin
      rvalid_d = rd_fire;
      rd_d     = rd_fire ? rd_word : rd_q;
    end
  end

  // Control and output registers
  always_ff @(posedge RWCLK) begin
    if (RESET) begin
      state_q  <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      cnt_q    <= '0;
      busy_q   <= (CLEAR_ON_RESET != 0);
      rd_q     <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      rd_q     <= rd_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign RD     = rd_q;
  assign RVALID = rvalid_q;
  assign BUSY   = busy_q;

endmodule

// File: tb/tb_ram_dp_param.sv
// Scoreboard bench for ram_dp_param: three configurations share clock/reset.
// u0: 8b x256, latency 1, read-old; u1: 8b x256, latency 2, write-first;
// u2: 32b x200, latency 1, read-old.
module tb_ram_dp_param;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] due;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        wen8, wbe8, ren8;
  logic [7:0]  waddr8, wd8, raddr8;
  logic [7:0]  rd0, rd1;
  logic        rv0, rv1, busy0, busy1;
  logic        wen32, ren32;
  logic [3:0]  wbe32;
  logic [7:0]  waddr32, raddr32;
  logic [31:0] wd32, rd2;
  logic        rv2, busy2;

  logic [31:0] cyc = '0;
  int          n_cmp = 0;
  int          n_fail = 0;
  exp_t        q0[$];
  exp_t        q1[$];
  exp_t        q2[$];

  ram_dp_param #(
    .DWIDTH(8), .AWIDTH(8), .DEPTH(256), .RD_LATENCY(1), .COLLISION_MODE(0),
    .CLEAR_ON_RESET(1), .CLEAR_VALUE(8'hA5)
  ) u0 (
    .RWCLK(clk), .RESET(rst), .WEN(wen8), .WBE(wbe8), .WADDR(waddr8), .WD(wd8),
    .REN(ren8), .RADDR(raddr8), .RD(rd0), .RVALID(rv0), .BUSY(busy0)
  );

  ram_dp_param #(
    .DWIDTH(8), .AWIDTH(8), .DEPTH(256), .RD_LATENCY(2), .COLLISION_MODE(1),
    .CLEAR_ON_RESET(1), .CLEAR_VALUE(8'hA5)
  ) u1 (
    .RWCLK(clk), .RESET(rst), .WEN(wen8), .WBE(wbe8), .WADDR(waddr8), .WD(wd8),
    .REN(ren8), .RADDR(raddr8), .RD(rd1), .RVALID(rv1), .BUSY(busy1)
  );

  ram_dp_param #(
    .DWIDTH(32), .AWIDTH(8), .DEPTH(200), .RD_LATENCY(1), .COLLISION_MODE(0),
    .CLEAR_ON_RESET(1), .CLEAR_VALUE(32'h1234_5678)
  ) u2 (
    .RWCLK(clk), .RESET(rst), .WEN(wen32), .WBE(wbe32), .WADDR(waddr32), .WD(wd32),
    .REN(ren32), .RADDR(raddr32), .RD(rd2), .RVALID(rv2), .BUSY(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic check_pop(input string name, input logic [31:0] got, input exp_t e);
    n_cmp++;
    if (got !== e.data || cyc !== e.due) begin
      n_fail++;
      $display("FAIL %s got=%h@%0d exp=%h@%0d", name, got, cyc, e.data, e.due);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] got);
    n_cmp++;
    n_fail++;
    $display("FAIL %s unexpected RVALID rd=%h at cycle %0d", name, got, cyc);
  endtask

  // Monitor: every RVALID strobe must match the oldest expected read
  always @(negedge clk) begin
    exp_t e;
    if (rv0) begin
      if (q0.size() == 0) unexpected("rd_u0", {24'h0, rd0});
      else begin e = q0.pop_front(); check_pop("rd_u0", {24'h0, rd0}, e); end
    end
    if (rv1) begin
      if (q1.size() == 0) unexpected("rd_u1", {24'h0, rd1});
      else begin e = q1.pop_front(); check_pop("rd_u1", {24'h0, rd1}, e); end
    end
    if (rv2) begin
      if (q2.size() == 0) unexpected("rd_u2", rd2);
      else begin e = q2.pop_front(); check_pop("rd_u2", rd2, e); end
    end
  end

  // One clock of 8-bit stimulus; e0/e1 are expected read data for u0/u1
  task automatic step8(input logic w, input logic [7:0] wa, input logic [7:0] d,
                       input logic be, input logic r, input logic [7:0] ra,
                       input logic [7:0] e0, input logic [7:0] e1);
    exp_t x;
    @(negedge clk);
    wen8 = w; waddr8 = wa; wd8 = d; wbe8 = be; ren8 = r; raddr8 = ra;
    if (r) begin
      x.data = {24'h0, e0}; x.due = cyc + 32'd1; q0.push_back(x);
      x.data = {24'h0, e1}; x.due = cyc + 32'd2; q1.push_back(x);
    end
  endtask

  // One clock of 32-bit stimulus for u2
  task automatic step32(input logic w, input logic [7:0] wa, input logic [31:0] d,
                        input logic [3:0] be, input logic r, input logic [7:0] ra,
                        input logic [31:0] e);
    exp_t x;
    @(negedge clk);
    wen32 = w; waddr32 = wa; wd32 = d; wbe32 = be; ren32 = r; raddr32 = ra;
    if (r) begin
      x.data = e; x.due = cyc + 32'd1; q2.push_back(x);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n0, n1, n2;
    rst = 1'b1;
    wen8 = 0; wbe8 = 0; ren8 = 0; waddr8 = '0; wd8 = '0; raddr8 = '0;
    wen32 = 0; wbe32 = '0; ren32 = 0; waddr32 = '0; wd32 = '0; raddr32 = '0;

    // Two reset clocks, then check reset state
    repeat (2) @(negedge clk);
    check("reset_rd0", {24'h0, rd0}, 32'h0);
    check("reset_rv1", {31'h0, rv1}, 32'h0);
    check("reset_busy", {29'h0, busy0, busy1, busy2}, 32'h7);
    rst = 1'b0;

    // Abort the clear at count 100 with a one-clock reset
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midreset_busy", {29'h0, busy0, busy1, busy2}, 32'h7);
    rst = 1'b0;
    wen8 = 1; wbe8 = 1; waddr8 = 8'd3; wd8 = 8'h11; ren8 = 1; raddr8 = 8'd3;
    wen32 = 1; wbe32 = 4'hF; waddr32 = 8'd3; wd32 = 32'h1111_1111; ren32 = 1; raddr32 = 8'd3;
    n0 = 0; n1 = 0; n2 = 0;
    fork
      while (busy0 && n0 < 1000) begin n0++; @(negedge clk); end
      while (busy1 && n1 < 1000) begin n1++; @(negedge clk); end
      while (busy2 && n2 < 1000) begin n2++; @(negedge clk); end
      begin
        repeat (4) @(negedge clk);
        wen8 = 0; ren8 = 0; wen32 = 0; ren32 = 0;
      end
    join
    check("busy_len_u0", 32'(n0), 32'd256);
    check("busy_len_u1", 32'(n1), 32'd256);
    check("busy_len_u2", 32'(n2), 32'd200);

    // Cleared contents, including the word written during BUSY
    step8(0, 8'd0, 8'h00, 0, 1, 8'd0,   8'hA5, 8'hA5);
    step8(0, 8'd0, 8'h00, 0, 1, 8'd128, 8'hA5, 8'hA5);
    step8(0, 8'd0, 8'h00, 0, 1, 8'd255, 8'hA5, 8'hA5);
    step8(0, 8'd0, 8'h00, 0, 1, 8'd3,   8'hA5, 8'hA5);

    // Collision: read-old on u0, write-first on u1
    step8(1, 8'd7, 8'h3C, 1, 0, 8'd0, 8'h00, 8'h00);
    step8(1, 8'd7, 8'hC3, 1, 1, 8'd7, 8'h3C, 8'hC3);
    step8(0, 8'd0, 8'h00, 0, 1, 8'd7, 8'hC3, 8'hC3);

    // Back-to-back reads of 10/20/30
    step8(1, 8'd1, 8'h10, 1, 0, 8'd0, 8'h00, 8'h00);
    step8(1, 8'd2, 8'h20, 1, 0, 8'd0, 8'h00, 8'h00);
    step8(1, 8'd3, 8'h30, 1, 0, 8'd0, 8'h00, 8'h00);
    step8(0, 8'd0, 8'h00, 0, 1, 8'd1, 8'h10, 8'h10);
    step8(0, 8'd0, 8'h00, 0, 1, 8'd2, 8'h20, 8'h20);
    step8(0, 8'd0, 8'h00, 0, 1, 8'd3, 8'h30, 8'h30);
    repeat (4) step8(0, 8'd0, 8'h00, 0, 0, 8'd0, 8'h00, 8'h00);
    check("hold_rv", {30'h0, rv0, rv1}, 32'h0);
    check("hold_rd", {16'h0, rd0, rd1}, 32'h3030);

    // In-flight read is not disturbed by a following write
    step8(0, 8'd0, 8'h00, 0, 1, 8'd1, 8'h10, 8'h10);
    step8(1, 8'd1, 8'h55, 1, 0, 8'd0, 8'h00, 8'h00);
    step8(0, 8'd0, 8'h00, 0, 1, 8'd1, 8'h55, 8'h55);

    // WEN with no lanes enabled is a no-op
    step8(1, 8'd2, 8'hFF, 0, 0, 8'd0, 8'h00, 8'h00);
    step8(0, 8'd0, 8'h00, 0, 1, 8'd2, 8'h20, 8'h20);
    step8(0, 8'd0, 8'h00, 0, 0, 8'd0, 8'h00, 8'h00);

    // 32-bit byte lanes
    step32(1, 8'd5, 32'h0000_0000, 4'hF, 0, 8'd0, 32'h0);
    step32(1, 8'd5, 32'hDEAD_BEEF, 4'b0101, 0, 8'd0, 32'h0);
    step32(0, 8'd0, 32'h0, 4'h0, 1, 8'd5, 32'h00AD_00EF);

    // Out of range write dropped, read returns zero
    step32(1, 8'd220, 32'hFFFF_FFFF, 4'hF, 0, 8'd0, 32'h0);
    step32(0, 8'd0, 32'h0, 4'h0, 1, 8'd220, 32'h0);
    step32(0, 8'd0, 32'h0, 4'h0, 1, 8'd199, 32'h1234_5678);
    step32(0, 8'd0, 32'h0, 4'h0, 1, 8'd3,   32'h1234_5678);

    // Partial-lane collision in read-old mode
    step32(1, 8'd9, 32'h1122_3344, 4'hF, 0, 8'd0, 32'h0);
    step32(1, 8'd9, 32'hAABB_CCDD, 4'b1000, 1, 8'd9, 32'h1122_3344);
    step32(0, 8'd0, 32'h0, 4'h0, 1, 8'd9, 32'hAA22_3344);
    repeat (4) step32(0, 8'd0, 32'h0, 4'h0, 0, 8'd0, 32'h0);

    check("queues_drained", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_dp_param.md
Name: ram_dp_param

Overview:
Parametrised simple dual-port synchronous RAM. It is the successor to the fixed 256x8 scratch RAM used by the APB controller cores. Data width, depth and read latency are configurable. Adds byte-lane write enables and a selectable read/write collision policy. On reset it runs a hardware clear sequencer that initialises every word and flags BUSY until done. One write port and one read port share a single clock.

Parameters:
DWIDTH, 8, data width in bits (1..64); byte lanes NBE = ceil(DWIDTH/8), last lane may be partial.
AWIDTH, 8, address width in bits (1..12).
DEPTH, 256, number of words; must satisfy 1 <= DEPTH <= 2**AWIDTH.
RD_LATENCY, 1, read latency in clocks from REN sample to RD update; legal values 1 or 2.
COLLISION_MODE, 0, 0 = read-old (same-address read returns pre-write data); 1 = write-first (returns merged new data).
CLEAR_ON_RESET, 1, 1 = run the clear sequence after RESET; 0 = no clear, BUSY tied low.
CLEAR_VALUE, 0, DWIDTH-bit value written to every word by the clear sequence.

Ports:
RWCLK  input  1  single clock, all logic on rising edge.
RESET  input  1  synchronous, active-high reset.
WEN  input  1  write enable, sampled on RWCLK.
WBE  input  NBE  byte-lane write enables; lane i = WD[8i+7:8i].
WADDR  input  AWIDTH  write address.
WD  input  DWIDTH  write data.
REN  input  1  read enable, sampled on RWCLK.
RADDR  input  AWIDTH  read address.
RD  output  DWIDTH  read data, registered.
RVALID  output  1  one-cycle strobe marking RD updated by a read.
BUSY  output  1  clear sequence in progress; user WEN/REN ignored.

Behaviour:
- Reset: one clock; reset is synchronous and active-high. Clock port is RWCLK; reset port is RESET.
- While RESET=1 at an edge: RD=0, RVALID=0, latency-2 pipeline stage cleared, clear counter=0.
- While RESET=1, BUSY=CLEAR_ON_RESET. Memory contents are not touched during reset itself.
- Clear FSM has two states: CLEAR and RUN. RESET forces CLEAR (if CLEAR_ON_RESET=1) or RUN (if 0).
- In CLEAR, each edge writes CLEAR_VALUE to word cnt and increments cnt.
- After the edge that writes word DEPTH-1, the FSM moves to RUN and BUSY falls. BUSY is high for exactly DEPTH edges after RESET deasserts.
- During BUSY, WEN/REN/WBE are ignored: no user write, no read, RVALID=0, RD holds 0.
- RESET asserted mid-clear restarts the count from 0 after release.
- Write: at an edge with WEN=1, BUSY=0 and WADDR<DEPTH, each lane with WBE[i]=1 takes WD lane i. Lanes with WBE[i]=0 keep their contents. WEN=1 with WBE=0 is a no-op.
- Write with WADDR>=DEPTH is dropped silently.
- Read, RD_LATENCY=1: REN=1 sampled at edge N (BUSY=0) -> RD holds mem[RADDR] and RVALID=1 after edge N.
- Read, RD_LATENCY=2: the same read yields RD and RVALID after edge N+1. Back-to-back reads are fully pipelined, one per clock.
- RADDR>=DEPTH: RD=0, RVALID still asserted.
- No read issued: RVALID=0 and RD holds its last value.
- Collision (WEN=1, REN=1, WADDR==RADDR<DEPTH, same edge):
  - Mode 0: RD returns the pre-write word.
  - Mode 1: RD returns the merged word, taking WBE lanes from WD and the remaining lanes from old data.
  - Memory is always updated.
- Read one cycle after a write to the same address always returns the new data in both modes.
- Latency-2 pipeline holds the value captured at edge N. A write at edge N+1 does not alter the in-flight read data.

Test Plan:
- Clear: DEPTH=256, CLEAR_VALUE=8'hA5; pulse RESET 2 cycles, release -> BUSY high exactly 256 clocks; then reading addresses 0, 128, 255 returns A5 each with RVALID=1 one clock after REN.
- Reset mid-clear: assert RESET at clear count 100 for 1 cycle -> BUSY restarts and stays high 256 clocks after release. During BUSY, WEN to addr 3 with D=0x11 is ignored; reading addr 3 afterwards returns A5.
- Byte enables: DWIDTH=32, mem[5]=32'h00000000; write WD=32'hDEADBEEF, WBE=4'b0101 -> read addr 5 returns 32'h00AD00EF.
- Collision: mem[7]=8'h3C; same edge WEN/REN addr 7, WD=8'hC3 -> mode 0 RD=3C, mode 1 RD=C3. The next read of addr 7 returns C3 in both modes.
- Latency 2: REN on consecutive edges to addrs 1, 2, 3 holding 10, 20, 30 -> RVALID high for 3 cycles starting two edges after the first REN, RD=10, 20, 30. With REN low afterwards, RVALID drops and RD holds 30.
- Out of range: DEPTH=200, AWIDTH=8; write addr 220 D=0xFF, then read addr 220 -> RD=0, RVALID=1. Read addr 199 still returns CLEAR_VALUE.
